// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: group width, op encoding and the result flag bundle.
package alu_pkg;

    localparam int unsigned GRP_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } alu_flags_t;

endpackage

// File: rtl/pg_gen4.sv
// Combinational 4-bit propagate/generate cell: per-bit p/g plus group P/G.
module pg_gen4
    import alu_pkg::*;
(
    input  logic [GRP_W-1:0] a_i,
    input  logic [GRP_W-1:0] b_i,
    output logic [GRP_W-1:0] p_o,
    output logic [GRP_W-1:0] g_o,
    output logic             gp_o,
    output logic             gg_o
);

    assign p_o  = a_i ^ b_i;
    assign g_o  = a_i & b_i;
    assign gp_o = &p_o;
    assign gg_o = g_o[3]
                | (p_o[3] & g_o[2])
                | (p_o[3] & p_o[2] & g_o[1])
                | (p_o[3] & p_o[2] & p_o[1] & g_o[0]);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers p/g and group P/G; stage 2 resolves carries and registers sum and flags.
module cla_pipe_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic             ovf_o
);

    localparam int unsigned NG  = WIDTH / GRP_W;
    localparam int unsigned MSB = WIDTH - 1;

    if ((WIDTH % GRP_W) != 0 || WIDTH < 8) begin : g_width_check
        $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    // Handshake
    logic adv1, adv2, accept, s2_load;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_p_q, s1_g_q;
    logic [NG-1:0]    s1_gp_q, s1_gg_q;
    logic             s1_cin_q, s1_a_msb_q, s1_b_msb_q;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q;
    alu_flags_t       flags_q;

    assign adv2       = !out_valid_q || out_ready_i;
    assign adv1       = !s1_valid_q || adv2;
    assign in_ready_o = adv1;
    assign accept     = in_valid_i && adv1;
    assign s2_load    = s1_valid_q && adv2;

    // Stage 1: operand conditioning and P/G generation
    logic             cin_w;
    logic [WIDTH-1:0] b_eff_w, p_w, g_w;
    logic [NG-1:0]    gp_w, gg_w;

    assign cin_w   = (op_i != OP_ADD);
    assign b_eff_w = (op_i == OP_SUB) ? ~b_i : b_i;

    for (genvar k = 0; k < NG; k++) begin : g_pg
        pg_gen4 u_pg_gen4 (
            .a_i  (a_i[k*GRP_W +: GRP_W]),
            .b_i  (b_eff_w[k*GRP_W +: GRP_W]),
            .p_o  (p_w[k*GRP_W +: GRP_W]),
            .g_o  (g_w[k*GRP_W +: GRP_W]),
            .gp_o (gp_w[k]),
            .gg_o (gg_w[k])
        );
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (adv1) begin
            s1_valid_d = in_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_g_q     <= '0;
            s1_gp_q    <= '0;
            s1_gg_q    <= '0;
            s1_cin_q   <= 1'b0;
            s1_a_msb_q <= 1'b0;
            s1_b_msb_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                s1_p_q     <= p_w;
                s1_g_q     <= g_w;
                s1_gp_q    <= gp_w;
                s1_gg_q    <= gg_w;
                s1_cin_q   <= cin_w;
                s1_a_msb_q <= a_i[MSB];
                s1_b_msb_q <= b_eff_w[MSB];
            end
        end
    end

    // Stage 2: each group carry is a flat sum of products over the group terms, so the
    // depth is one lookahead level rather than a chain through the groups.
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] bit_c, sum_w;
    alu_flags_t       flags_w;

    always_comb begin
        logic acc;
        logic term;
        grp_c[0] = s1_cin_q;
        for (int k = 0; k < NG; k++) begin
            acc = s1_cin_q;
            for (int m = 0; m <= k; m++) begin
                acc = acc & s1_gp_q[m];
            end
            for (int j = 0; j <= k; j++) begin
                term = s1_gg_q[j];
                for (int m = j + 1; m <= k; m++) begin
                    term = term & s1_gp_q[m];
                end
                acc = acc | term;
            end
            grp_c[k+1] = acc;
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_intra
        localparam int unsigned B = k * GRP_W;
        assign bit_c[B]   = grp_c[k];
        assign bit_c[B+1] = s1_g_q[B] | (s1_p_q[B] & grp_c[k]);
        assign bit_c[B+2] = s1_g_q[B+1]
                          | (s1_p_q[B+1] & s1_g_q[B])
                          | (s1_p_q[B+1] & s1_p_q[B] & grp_c[k]);
        assign bit_c[B+3] = s1_g_q[B+2]
                          | (s1_p_q[B+2] & s1_g_q[B+1])
                          | (s1_p_q[B+2] & s1_p_q[B+1] & s1_g_q[B])
                          | (s1_p_q[B+2] & s1_p_q[B+1] & s1_p_q[B] & grp_c[k]);
    end

    assign sum_w         = s1_p_q ^ bit_c;
    assign flags_w.carry = grp_c[NG];
    assign flags_w.zero  = (sum_w == '0);
    assign flags_w.neg   = sum_w[MSB];
    assign flags_w.ovf   = (s1_a_msb_q == s1_b_msb_q) && (sum_w[MSB] != s1_a_msb_q);

    // Output stage
    always_comb begin
        out_valid_d = out_valid_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s2_load) begin
                sum_q   <= sum_w;
                flags_q <= flags_w;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum_o       = sum_q;
    assign carry_o     = flags_q.carry;
    assign zero_o      = flags_q.zero;
    assign neg_o       = flags_q.neg;
    assign ovf_o       = flags_q.ovf;

endmodule
